nx_dff_pipe: RTL and testbench

Elastic register pipeline for the NanoXplore flow, built entirely from asynchronously cleared NX_DFF flops (the flop flavour that ABC9 keeps as boxes rather than retiming). It moves WIDTH-bit words through DEPTH stages with valid/ready flow control and a global load enable. It is the consumer-side counterpart to the sync-only flop mapping: a known-good async-clear structure for exercising and benchmarking the boxed-flop path. It sits between any producer and consumer that need a fixed-latency, stallable delay line.

---
 rtl/nx_dff_pipe.sv | 107 ++++++++++
 tb/tb_nx_dff_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/nx_dff_pipe.sv
// nx_dff_pipe: elastic WIDTH x DEPTH register pipeline with valid/ready flow control
// and a global load enable. Every flop is asynchronously cleared by R.
// Optional feature: define NX_DFF_PIPE_OCC_EN to add the OCC occupancy counter port.
module nx_dff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter bit               dff_edge  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       CK,
  input  logic                       R,
  input  logic                       L,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VALID,
  output logic                       I_READY,
  output logic [WIDTH-1:0]           O,
  output logic                       O_VALID,
`ifdef NX_DFF_PIPE_OCC_EN
  input  logic                       O_READY,
  output logic [$clog2(DEPTH+1)-1:0] OCC
`else
  input  logic                       O_READY
`endif
);

  // Inverting the clock selects the falling edge; folds to a plain wire when dff_edge=0.
  logic clk_act;
  assign clk_act = CK ^ dff_edge;

  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] rdy;
  logic             tail_full;

  // Stage k can accept unless it and every stage downstream are full and the consumer stalls.
  // Written as a flat reduction so the ready chain is not a self-referencing vector.
  always_comb begin
    rdy       = '0;
    tail_full = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tail_full = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        tail_full = tail_full & v_q[j];
      end
      rdy[k] = O_READY | ~tail_full;
    end
  end

  // Upstream source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    up_v    = '0;
    up_v[0] = I_VALID;
    up_d[0] = I;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v_q[k-1];
      up_d[k] = d_q[k-1];
    end
  end

  // Stage registers: load from upstream when ready, data only moves with a valid word.
  always_ff @(posedge clk_act or posedge R) begin
    if (R) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else if (L) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_q[k] <= up_v[k];
          if (up_v[k]) begin
            d_q[k] <= up_d[k];
          end
        end
      end
    end
  end

  assign I_READY = L & ~R & rdy[0];
  assign O       = d_q[DEPTH-1];
  assign O_VALID = v_q[DEPTH-1];

`ifdef NX_DFF_PIPE_OCC_EN
  logic                       xfer_in;
  logic                       xfer_out;
  logic [$clog2(DEPTH+1)-1:0] occ_q;

  assign xfer_in  = I_VALID & I_READY;
  assign xfer_out = O_VALID & O_READY & L;

  // Occupancy count; a simultaneous in and out leaves it unchanged.
  always_ff @(posedge clk_act or posedge R) begin
    if (R) begin
      occ_q <= '0;
    end else if (xfer_in && !xfer_out) begin
      occ_q <= occ_q + 1'b1;
    end else if (xfer_out && !xfer_in) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_nx_dff_pipe.sv
// Bench for nx_dff_pipe: rising-edge and falling-edge instances, scoreboard of accepted words.
module tb_nx_dff_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned OW = $clog2(D + 1);
  localparam logic [W-1:0] RV = 8'h5A;

  logic          CK = 1'b0;
  logic          R;
  logic          L0, IV0, OR0, L1, IV1, OR1;
  logic [W-1:0]  I0, I1;
  logic          IR0, OV0, IR1, OV1;
  logic [W-1:0]  O0, O1;
`ifdef NX_DFF_PIPE_OCC_EN
  logic [OW-1:0] OCC0, OCC1;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];

  always #5 CK = ~CK;

  nx_dff_pipe #(.WIDTH(W), .DEPTH(D), .dff_edge(1'b0), .RESET_VAL(RV)) dut0 (
    .CK(CK), .R(R), .L(L0), .I(I0), .I_VALID(IV0), .I_READY(IR0),
    .O(O0), .O_VALID(OV0),
`ifdef NX_DFF_PIPE_OCC_EN
    .OCC(OCC0),
`endif
    .O_READY(OR0)
  );

  nx_dff_pipe #(.WIDTH(W), .DEPTH(D), .dff_edge(1'b1), .RESET_VAL(RV)) dut1 (
    .CK(CK), .R(R), .L(L1), .I(I1), .I_VALID(IV1), .I_READY(IR1),
    .O(O1), .O_VALID(OV1),
`ifdef NX_DFF_PIPE_OCC_EN
    .OCC(OCC1),
`endif
    .O_READY(OR1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One cycle on the selected instance; exp_ir/exp_ov < 0 means don't care.
  task automatic cyc(input bit sel, input bit iv, input logic [W-1:0] din, input bit ordy,
                     input bit ld, input int exp_ir, input int exp_ov);
    logic         ir, ov, have_front;
    logic [W-1:0] o, front;
    if (sel) begin IV1 = iv; I1 = din; OR1 = ordy; L1 = ld; end
    else     begin IV0 = iv; I0 = din; OR0 = ordy; L0 = ld; end
    #1;
    ir = sel ? IR1 : IR0;
    ov = sel ? OV1 : OV0;
    o  = sel ? O1 : O0;
    if (exp_ir >= 0) check("i_ready", {31'b0, ir}, exp_ir);
    if (exp_ov >= 0) check("o_valid", {31'b0, ov}, exp_ov);
`ifdef NX_DFF_PIPE_OCC_EN
    check("occ", {29'b0, (sel ? OCC1 : OCC0)}, q.size());
`endif
    have_front = (q.size() != 0);
    front      = have_front ? q[0] : '0;
    if (ov && ordy && ld) begin
      check("sb_nonempty", {31'b0, have_front}, 1);
      if (have_front) check("o_data", {24'b0, o}, {24'b0, q.pop_front()});
    end else if (ov && have_front) begin
      check("o_hold", {24'b0, o}, {24'b0, front});
    end
    if (iv && ir) q.push_back(din);
    if (sel) begin
      // Rising edge must not disturb the falling-edge instance.
      @(posedge CK); #1;
      if (exp_ov >= 0) check("fall_rise_v", {31'b0, OV1}, exp_ov);
      if (exp_ov == 1 && have_front) check("fall_rise_d", {24'b0, O1}, {24'b0, front});
      @(negedge CK); #1;
    end else begin
      @(posedge CK); #1;
    end
  endtask

  initial begin
    R = 1'b1;
    L0 = 1'b1; IV0 = 1'b1; I0 = 8'hAA; OR0 = 1'b1;
    L1 = 1'b1; IV1 = 1'b1; I1 = 8'hBB; OR1 = 1'b1;

    // Reset held with offered input and running clock
    repeat (3) @(posedge CK);
    #1;
    check("rst_o", {24'b0, O0}, {24'b0, RV});
    check("rst_ov", {31'b0, OV0}, 0);
    check("rst_ir", {31'b0, IR0}, 0);
    check("rst_o_fall", {24'b0, O1}, {24'b0, RV});
    check("rst_ir_fall", {31'b0, IR1}, 0);
`ifdef NX_DFF_PIPE_OCC_EN
    check("rst_occ", {29'b0, OCC0}, 0);
`endif
    R = 1'b0; IV0 = 1'b0; IV1 = 1'b0;

    // Streaming 0x01..0x10, first valid 3 edges after first acceptance
    for (int i = 0; i < 16; i++) cyc(0, 1, W'(i + 1), 1, 1, 1, (i < 4) ? 0 : 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 1, 1, 1);
    cyc(0, 0, '0, 1, 1, 1, 0);
    check("stream_drained", q.size(), 0);

    // Backpressure fill: exactly four accepted
    for (int i = 0; i < 6; i++)
      cyc(0, 1, (i < 4) ? W'(8'h21 + i) : 8'h25, 0, 1, (i < 4) ? 1 : 0, (i < 4) ? 0 : 1);
    check("fill_count", q.size(), 4);
`ifdef NX_DFF_PIPE_OCC_EN
    check("occ_full", {29'b0, OCC0}, 4);
`endif
    // Full with simultaneous in/out
    for (int i = 0; i < 6; i++) cyc(0, 1, W'(8'h25 + i), 1, 1, 1, 1);
    check("full_level", q.size(), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 1, 1, 1);
    cyc(0, 0, '0, 1, 1, 1, 0);
    check("full_drained", q.size(), 0);

    // Load enable freeze mid-stream
    for (int i = 0; i < 6; i++) cyc(0, 1, W'(8'h41 + i), 1, 1, 1, (i < 4) ? 0 : 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h47, 1, 0, 0, 1);
    check("freeze_level", q.size(), 4);
    for (int i = 0; i < 6; i++) cyc(0, 1, W'(8'h47 + i), 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 1, 1, 1);
    cyc(0, 0, '0, 1, 1, 1, 0);
    check("freeze_drained", q.size(), 0);

    // Asynchronous reset with three words in flight
    for (int i = 0; i < 3; i++) cyc(0, 1, W'(8'h61 + i), 0, 1, 1, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    cyc(0, 0, '0, 0, 1, 1, 1);
    #2;
    R = 1'b1;
    #1;
    check("arst_ov", {31'b0, OV0}, 0);
    check("arst_o", {24'b0, O0}, {24'b0, RV});
    check("arst_ir", {31'b0, IR0}, 0);
`ifdef NX_DFF_PIPE_OCC_EN
    check("arst_occ", {29'b0, OCC0}, 0);
`endif
    q.delete();
    @(posedge CK); #1;
    check("arst_hold_ov", {31'b0, OV0}, 0);
    R = 1'b0;

    // Falling-edge instance: same streaming sequence
    @(negedge CK); #1;
    for (int i = 0; i < 16; i++) cyc(1, 1, W'(i + 1), 1, 1, 1, (i < 4) ? 0 : 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 1, 1, 1, 1);
    cyc(1, 0, '0, 1, 1, 1, 0);
    check("fall_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
